io_cmos_dly_code_stepper: RTL and testbench

Sequencer for the 7-bit gray control code of the NAND delay-line decoder. It accepts a binary target delay code through a valid/ready handshake. It then walks the registered gray output toward the target one code per step, so exactly one gray bit changes per step. After every step it waits a programmable settle interval before the next step. It sits between the DLL/calibration logic and the delay-line decoder and guarantees glitch-free delay updates.

---
 rtl/io_cmos_dly_code_stepper_pkg.sv | 21 ++
 rtl/io_cmos_dly_code_stepper_if.sv | 24 ++
 rtl/io_cmos_dly_code_stepper_bin2gray7.sv | 12 +
 rtl/io_cmos_dly_code_stepper.sv | 101 ++++++++++
 tb/tb_io_cmos_dly_code_stepper.sv | 383 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/io_cmos_dly_code_stepper_pkg.sv
// Shared types, constants and the binary-to-gray code mapping
// used by the NAND delay-line code stepper.
package io_cmos_dly_pkg;

  localparam int CODE_W = 7;
  localparam logic [CODE_W-1:0] MAX_CODE = 7'd64;

  typedef enum logic [1:0] {
    IDLE,
    STEP,
    SETTLE
  } state_e;

  // The low six bits saturate at 63 so that 63->64 flips only bit 6.
  function automatic logic [CODE_W-1:0] bin2gray7(input logic [CODE_W-1:0] c);
    logic [5:0] x;
    x = (c > 7'd63) ? 6'd63 : c[5:0];
    return {c[6], x ^ (x >> 1)};
  endfunction

endpackage

// File: rtl/io_cmos_dly_code_stepper_if.sv
// Target handshake plus code/status outputs of the delay code stepper.
interface io_cmos_dly_code_stepper_if;
  import io_cmos_dly_pkg::*;

  logic [CODE_W-1:0] tgt_code;
  logic              tgt_valid;
  logic              tgt_ready;
  logic              freeze;
  logic [CODE_W-1:0] gray;
  logic [CODE_W-1:0] cur_code;
  logic              busy;
  logic              done;

  modport master (
    output tgt_code, tgt_valid, freeze,
    input  tgt_ready, gray, cur_code, busy, done
  );

  modport slave (
    input  tgt_code, tgt_valid, freeze,
    output tgt_ready, gray, cur_code, busy, done
  );

endinterface

// File: rtl/io_cmos_dly_code_stepper_bin2gray7.sv
// Combinational binary-to-gray map; fed with the next code so the
// gray output can be registered directly.
module io_cmos_dly_bin2gray7
  import io_cmos_dly_pkg::*;
(
  input  logic [CODE_W-1:0] bin,
  output logic [CODE_W-1:0] gray
);

  assign gray = bin2gray7(bin);

endmodule

// File: rtl/io_cmos_dly_code_stepper.sv
// Walks the registered gray delay code one step at a time toward an
// accepted target, with a settle interval after each step.
//
// state  | meaning
// IDLE   | waiting for a target; tgt_ready high unless frozen
// STEP   | move code one toward target, or finish with done if already there
// SETTLE | count down the settle interval before the next STEP
module io_cmos_dly_code_stepper
  import io_cmos_dly_pkg::*;
#(
  parameter int SETTLE_CYC = 4,
  parameter int RESET_CODE = 0
) (
  input  logic                        clk,
  input  logic                        reset_n,
  io_cmos_dly_code_stepper_if.slave   bus
);

  localparam logic [CODE_W-1:0] RST_CODE = CODE_W'(RESET_CODE);
  localparam logic [3:0]        CNT_LOAD = 4'(SETTLE_CYC - 1);

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [CODE_W-1:0] cur_q, cur_d;
  logic [CODE_W-1:0] tgt_q, tgt_d;
  logic [CODE_W-1:0] gray_q, gray_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [CODE_W-1:0] tgt_clamp;

  assign tgt_clamp = (bus.tgt_code > MAX_CODE) ? MAX_CODE : bus.tgt_code;

  io_cmos_dly_bin2gray7 u_bin2gray7 (
    .bin  (cur_d),
    .gray (gray_d)
  );

  // Every transition is gated by freeze so a frozen cycle is a pure stall.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!bus.freeze) begin
      case (state_q)
        IDLE: begin
          if (bus.tgt_valid) begin
            tgt_d   = tgt_clamp;
            busy_d  = (tgt_clamp != cur_q);
            state_d = STEP;
          end
        end
        STEP: begin
          if (cur_q == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            cur_d   = (tgt_q > cur_q) ? cur_q + 7'd1 : cur_q - 7'd1;
            cnt_d   = CNT_LOAD;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
          else               state_d = STEP;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      cur_q   <= RST_CODE;
      tgt_q   <= RST_CODE;
      gray_q  <= bin2gray7(RST_CODE);
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.tgt_ready = (state_q == IDLE) & ~bus.freeze;
  assign bus.gray      = gray_q;
  assign bus.cur_code  = cur_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_io_cmos_dly_code_stepper.sv
// Directed and random checks of the delay code stepper (SETTLE_CYC=4, RESET_CODE=0).
module tb_io_cmos_dly_code_stepper;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   ecnt;

  io_cmos_dly_code_stepper_if bus();

  io_cmos_dly_code_stepper #(.SETTLE_CYC(4), .RESET_CODE(0)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  function automatic logic [6:0] gmap(input logic [6:0] c);
    logic [5:0] x;
    if (c >= 7'd64) return 7'b1100000;
    x = c[5:0];
    return {1'b0, x ^ {1'b0, x[5:1]}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
  endtask

  task automatic accept(input logic [6:0] code);
    int n;
    n = 0;
    while (!bus.tgt_ready && n < 50) begin
      tick();
      n++;
    end
    if (!bus.tgt_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout tgt_ready=%b want 1", bus.tgt_ready);
    end
    bus.tgt_code  = code;
    bus.tgt_valid = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    ecnt = 0;
  endtask

  task automatic wait_done(input int max_edges, output int e);
    e = -1;
    for (int i = 0; i < max_edges; i++) begin
      tick();
      if (bus.done) begin
        e = ecnt;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n       = 1'b0;
    bus.freeze    = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_code  = 7'd0;
    repeat (3) tick();
    checks++;
    if (bus.gray !== 7'b0000000 || bus.cur_code !== 7'd0) begin
      errors++;
      $display("FAIL reset_code gray=%b cur=%0d want 0000000/0", bus.gray, bus.cur_code);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_status busy=%b done=%b ready=%b want 0/0/1", bus.busy, bus.done, bus.tgt_ready);
    end
    reset_n = 1'b1;
    tick();
    bus.freeze = 1'b1;
    #1;
    checks++;
    if (bus.tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_freeze_ready ready=%b want 0", bus.tgt_ready);
    end
    bus.freeze = 1'b0;
    tick();
  endtask

  task automatic test_up_walk();
    int e;
    accept(7'd3);
    tick();
    checks++;
    if (bus.gray !== 7'b0000001 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL up_step1 gray=%b busy=%b want 0000001/1", bus.gray, bus.busy);
    end
    repeat (4) tick();
    checks++;
    if (bus.gray !== 7'b0000001) begin
      errors++;
      $display("FAIL up_settle_hold gray=%b want 0000001", bus.gray);
    end
    tick();
    checks++;
    if (bus.gray !== 7'b0000011) begin
      errors++;
      $display("FAIL up_step2 gray=%b want 0000011", bus.gray);
    end
    repeat (5) tick();
    checks++;
    if (bus.gray !== 7'b0000010) begin
      errors++;
      $display("FAIL up_step3 gray=%b want 0000010", bus.gray);
    end
    wait_done(20, e);
    checks++;
    if (e != 16) begin
      errors++;
      $display("FAIL up_done_edge edge=%0d want 16", e);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.tgt_ready !== 1'b1 || bus.cur_code !== 7'd3) begin
      errors++;
      $display("FAIL up_end busy=%b ready=%b cur=%0d want 0/1/3", bus.busy, bus.tgt_ready, bus.cur_code);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL up_done_pulse done=%b want 0", bus.done);
    end
  endtask

  task automatic test_saturation();
    int e;
    logic [6:0] prev;
    accept(7'd62);
    wait_done(400, e);
    checks++;
    if (e != 296 || bus.cur_code !== 7'd62 || bus.gray !== 7'b0100001) begin
      errors++;
      $display("FAIL sat_reach62 edge=%0d cur=%0d gray=%b want 296/62/0100001", e, bus.cur_code, bus.gray);
    end
    accept(7'd100);
    tick();
    checks++;
    if (bus.gray !== 7'b0100000 || bus.cur_code !== 7'd63) begin
      errors++;
      $display("FAIL sat_63 gray=%b cur=%0d want 0100000/63", bus.gray, bus.cur_code);
    end
    prev = bus.gray;
    repeat (5) tick();
    checks++;
    if (bus.gray !== 7'b1100000 || (prev ^ bus.gray) !== 7'b1000000) begin
      errors++;
      $display("FAIL sat_64 gray=%b diff=%b want 1100000/1000000", bus.gray, prev ^ bus.gray);
    end
    wait_done(20, e);
    checks++;
    if (e != 11 || bus.cur_code !== 7'd64) begin
      errors++;
      $display("FAIL sat_done edge=%0d cur=%0d want 11/64", e, bus.cur_code);
    end
  endtask

  task automatic test_down_noop();
    int e;
    logic [6:0] exp_g [4];
    logic [6:0] prev;
    exp_g[0] = 7'b0100000;
    exp_g[1] = 7'b0100001;
    exp_g[2] = 7'b0100011;
    exp_g[3] = 7'b0100010;
    prev = bus.gray;
    accept(7'd60);
    for (int k = 0; k < 4; k++) begin
      while (ecnt < 1 + 5 * k) tick();
      checks++;
      if (bus.gray !== exp_g[k] || $countones(bus.gray ^ prev) != 1) begin
        errors++;
        $display("FAIL down_step%0d gray=%b want %b (prev %b)", k, bus.gray, exp_g[k], prev);
      end
      prev = bus.gray;
    end
    wait_done(20, e);
    checks++;
    if (e != 21 || bus.cur_code !== 7'd60) begin
      errors++;
      $display("FAIL down_done edge=%0d cur=%0d want 21/60", e, bus.cur_code);
    end
    accept(7'd60);
    checks++;
    if (bus.tgt_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL noop_accept ready=%b busy=%b want 0/0", bus.tgt_ready, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL noop_done done=%b busy=%b want 1/0", bus.done, bus.busy);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.tgt_ready !== 1'b1 || bus.gray !== 7'b0100010) begin
      errors++;
      $display("FAIL noop_after done=%b ready=%b gray=%b want 0/1/0100010", bus.done, bus.tgt_ready, bus.gray);
    end
  endtask

  task automatic test_freeze();
    int e;
    int bad;
    accept(7'd62);
    tick();
    checks++;
    if (bus.gray !== 7'b0100011) begin
      errors++;
      $display("FAIL frz_step1 gray=%b want 0100011", bus.gray);
    end
    tick();
    bus.freeze = 1'b1;
    bad = 0;
    repeat (3) begin
      tick();
      if (bus.gray !== 7'b0100011 || bus.done !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frz_hold bad_cycles=%0d want 0", bad);
    end
    bus.freeze = 1'b0;
    while (ecnt < 8) tick();
    checks++;
    if (bus.gray !== 7'b0100011) begin
      errors++;
      $display("FAIL frz_delay_hold gray=%b want 0100011", bus.gray);
    end
    tick();
    checks++;
    if (bus.gray !== 7'b0100001) begin
      errors++;
      $display("FAIL frz_step2 gray=%b want 0100001", bus.gray);
    end
    wait_done(20, e);
    checks++;
    if (e != 14 || bus.cur_code !== 7'd62) begin
      errors++;
      $display("FAIL frz_done edge=%0d cur=%0d want 14/62", e, bus.cur_code);
    end
    bus.freeze = 1'b1;
    tick();
    checks++;
    if (bus.tgt_ready !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL frz_idle ready=%b busy=%b want 0/0", bus.tgt_ready, bus.busy);
    end
    bus.freeze = 1'b0;
    #1;
    checks++;
    if (bus.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL frz_release ready=%b want 1", bus.tgt_ready);
    end
  endtask

  task automatic test_handshake();
    int e;
    accept(7'd60);
    repeat (3) tick();
    bus.tgt_code  = 7'd0;
    bus.tgt_valid = 1'b1;
    tick();
    bus.tgt_valid = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.tgt_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_busy busy=%b ready=%b want 1/0", bus.busy, bus.tgt_ready);
    end
    wait_done(20, e);
    checks++;
    if (e != 11 || bus.cur_code !== 7'd60) begin
      errors++;
      $display("FAIL hs_ignored edge=%0d cur=%0d want 11/60", e, bus.cur_code);
    end
    repeat (10) tick();
    checks++;
    if (bus.cur_code !== 7'd60 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL hs_no_queue cur=%0d busy=%b want 60/0", bus.cur_code, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    accept(7'd10);
    repeat (7) tick();
    checks++;
    if (bus.cur_code !== 7'd58 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre cur=%0d busy=%b want 58/1", bus.cur_code, bus.busy);
    end
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.gray !== 7'b0000000 || bus.cur_code !== 7'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid gray=%b cur=%0d busy=%b done=%b want 0000000/0/0/0",
               bus.gray, bus.cur_code, bus.busy, bus.done);
    end
    #2;
    reset_n = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.cur_code !== 7'd0 || bus.tgt_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_after cur=%0d ready=%b want 0/1", bus.cur_code, bus.tgt_ready);
    end
  endtask

  task automatic test_random();
    logic [6:0] t;
    logic [6:0] want;
    logic [6:0] prev;
    logic       seen;
    for (int it = 0; it < 6; it++) begin
      t    = 7'($urandom_range(0, 127));
      want = (t > 7'd64) ? 7'd64 : t;
      prev = bus.gray;
      accept(t);
      seen = 1'b0;
      for (int c = 0; c < 340 && !seen; c++) begin
        checks++;
        if ($countones(bus.gray ^ prev) > 1) begin
          errors++;
          $display("FAIL rnd_hamming gray=%b prev=%b want <=1 bit change", bus.gray, prev);
        end
        prev = bus.gray;
        tick();
        seen = bus.done;
      end
      checks++;
      if (!seen || bus.cur_code !== want || bus.gray !== gmap(want)) begin
        errors++;
        $display("FAIL rnd_final tgt=%0d done=%b cur=%0d gray=%b want cur %0d gray %b",
                 t, seen, bus.cur_code, bus.gray, want, gmap(want));
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    ecnt    = 0;
    reset_n = 1'b0;
    bus.freeze    = 1'b0;
    bus.tgt_valid = 1'b0;
    bus.tgt_code  = 7'd0;
    test_reset();
    test_up_walk();
    test_saturation();
    test_down_noop();
    test_freeze();
    test_handshake();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
